circuit1_tt_sweeper: RTL and testbench

- Self-running exhaustive stimulus/response stage wrapped around circuit_1.
- Upstream side: drives a,b,c through all 8 combinations.
- Downstream side: samples y after a programmable settle time, builds the captured truth table, compares it against an expected table and reports pass/fail plus the mismatch count.
- Used for in-fabric self-check of the combinational circuits and as the clocked harness for their benches.

---
 rtl/circuit1_tt_sweeper.sv | 108 ++++++++++
 tb/tb_circuit1_tt_sweeper.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/circuit1_tt_sweeper.sv
// Self-running truth-table sweeper for circuit_1: drives all 8 {a,b,c} vectors,
// samples y after SETTLE_CYC extra cycles and compares against EXP_TT. Option: SWEEP_STOP_ON_FAIL_EN.
module circuit1_tt_sweeper #(
  parameter logic [7:0]  EXP_TT     = 8'hE8,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] captured,
  output logic [3:0] mismatch_cnt
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  logic       sample_c;
  logic       miss_c;
  logic [7:0] cap_nxt_c;
  logic [3:0] mm_nxt_c;

  // Stimulus comes straight from the vector-index flops, so a/b/c are glitch-free.
  assign a = idx[2];
  assign b = idx[1];
  assign c = idx[0];

  // Sample-edge view of the result registers, including the current y.
  always_comb begin
    sample_c       = (state == HOLD) && (cnt == CNT_W'(SETTLE_CYC));
    miss_c         = (y != EXP_TT[idx]);
    cap_nxt_c      = captured;
    cap_nxt_c[idx] = y;
    mm_nxt_c       = mismatch_cnt + (miss_c ? 4'd1 : 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      captured     <= '0;
      mismatch_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= HOLD;
            idx          <= '0;
            cnt          <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            captured     <= '0;
            mismatch_cnt <= '0;
          end
        end
        HOLD: begin
          if (!sample_c) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt          <= '0;
            captured     <= cap_nxt_c;
            mismatch_cnt <= mm_nxt_c;
`ifdef SWEEP_STOP_ON_FAIL_EN
            // First mismatch ends the sweep; idx keeps the failing vector on a/b/c.
            if (miss_c) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b0;
            end else
`endif
            if (idx == IDX_W'(7)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (cap_nxt_c == EXP_TT);
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circuit1_tt_sweeper.sv
// Bench for circuit1_tt_sweeper: majority-gate response model with fault injection,
// scoreboard of expected sweep results checked when done rises.
module tb_circuit1_tt_sweeper;

  typedef struct {
    logic [7:0] cap;
    logic       pass;
    logic [3:0] mm;
    logic [2:0] abc;
    int         done_edge;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       fault;

  logic       start, y, a, b, c, busy, done, pass;
  logic [7:0] captured;
  logic [3:0] mismatch_cnt;

  logic       start0, y0, a0, b0, c0, busy0, done0, pass0;
  logic [7:0] captured0;
  logic [3:0] mismatch_cnt0;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  circuit1_tt_sweeper #(.EXP_TT(8'hE8), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .y(y),
    .busy(busy), .done(done), .pass(pass), .captured(captured),
    .mismatch_cnt(mismatch_cnt)
  );

  circuit1_tt_sweeper #(.EXP_TT(8'hE8), .SETTLE_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .c(c0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .captured(captured0),
    .mismatch_cnt(mismatch_cnt0)
  );

  // circuit_1 stand-in: 3-input majority, optionally inverted on vectors 3 and 6.
  always_comb begin
    y = (a & b) | (a & c) | (b & c);
    if (fault && ({a, b, c} == 3'd3 || {a, b, c} == 3'd6)) y = ~y;
    y0 = (a0 & b0) | (a0 & c0) | (b0 & c0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected sweep outcome derived from the response model, not from the DUT.
  function automatic exp_t make_exp(input logic f, input int settle);
    exp_t       e;
    logic [7:0] tt;
    logic [7:0] ref_tt;
    int         first;
    logic [2:0] v;
    ref_tt = 8'hE8;
    first  = -1;
    for (int i = 0; i < 8; i++) begin
      v     = 3'(i);
      tt[i] = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      if (f && (i == 3 || i == 6)) tt[i] = ~tt[i];
      if (first < 0 && tt[i] != ref_tt[i]) first = i;
    end
`ifdef SWEEP_STOP_ON_FAIL_EN
    if (first >= 0) begin
      e.cap       = tt & 8'((16'd2 << first) - 16'd1);
      e.pass      = 1'b0;
      e.mm        = 4'd1;
      e.abc       = 3'(first);
      e.done_edge = (first + 1) * (settle + 1);
      return e;
    end
`endif
    e.cap = tt;
    e.mm  = '0;
    for (int i = 0; i < 8; i++) e.mm += 4'(tt[i] ^ ref_tt[i]);
    e.pass      = (tt == ref_tt);
    e.abc       = 3'b111;
    e.done_edge = 8 * (settle + 1);
    return e;
  endfunction

  // One sweep on the SETTLE_CYC=2 instance; optional start pulses at cycles 5 and 9.
  task automatic run_sweep(input logic f, input bit pulse_mid, input string tag);
    exp_t e;
    int   n;
    fault = f;
    sb.push_back(make_exp(f, 2));
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_at_start"}, 32'(busy), 32'd1);
    check({tag, "_vec_at_start"}, 32'({a, b, c}), 32'd0);
    n = 0;
    while (!done && n < 100) begin
      if (pulse_mid && (n == 4 || n == 8)) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
      if (!done) check({tag, "_vec"}, 32'({a, b, c}), 32'(n / 3));
    end
    e = sb.pop_front();
    check({tag, "_done_edge"}, 32'(n), 32'(e.done_edge));
    check({tag, "_captured"}, 32'(captured), 32'(e.cap));
    check({tag, "_pass"}, 32'(pass), 32'(e.pass));
    check({tag, "_mismatch"}, 32'(mismatch_cnt), 32'(e.mm));
    check({tag, "_vec_final"}, 32'({a, b, c}), 32'(e.abc));
    check({tag, "_busy_final"}, 32'(busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   n;
    rst    = 1'b1;
    start  = 1'b0;
    start0 = 1'b0;
    fault  = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_captured", 32'(captured), 32'd0);
    check("reset_vec", 32'({a, b, c}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_sweep(1'b0, 1'b0, "match");
    check("match_done_hold", 32'(done), 32'd1);
    tick();
    check("done_holds", 32'(done), 32'd1);
    check("done_result_holds", 32'(captured), 32'hE8);

    run_sweep(1'b1, 1'b0, "fault");
    run_sweep(1'b0, 1'b1, "ignore_start");

    // Asynchronous reset mid-sweep, no clock edge in between.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_pass", 32'(pass), 32'd0);
    check("midrst_captured", 32'(captured), 32'd0);
    check("midrst_mismatch", 32'(mismatch_cnt), 32'd0);
    check("midrst_vec", 32'({a, b, c}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(1'b0, 1'b0, "after_rst");

    // start held high: back-to-back sweeps with one DONE cycle between them.
    fault = 1'b1;
    sb.push_back(make_exp(1'b1, 2));
    start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    check("b2b1_done_edge", 32'(n), 32'(e.done_edge));
    check("b2b1_captured", 32'(captured), 32'(e.cap));
    fault = 1'b0;
    sb.push_back(make_exp(1'b0, 2));
    tick();
    check("b2b_restart_done", 32'(done), 32'd0);
    check("b2b_restart_busy", 32'(busy), 32'd1);
    check("b2b_restart_captured", 32'(captured), 32'd0);
    check("b2b_restart_mismatch", 32'(mismatch_cnt), 32'd0);
    check("b2b_restart_vec", 32'({a, b, c}), 32'd0);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check("b2b2_done_edge", 32'(n), 32'(e.done_edge));
    check("b2b2_captured", 32'(captured), 32'(e.cap));
    check("b2b2_pass", 32'(pass), 32'(e.pass));

    // SETTLE_CYC=0 instance: one cycle per vector, done 8 edges after start.
    e = make_exp(1'b0, 0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("s0_busy", 32'(busy0), 32'd1);
    check("s0_vec0", 32'({a0, b0, c0}), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) begin
        check("s0_vec", 32'({a0, b0, c0}), 32'(i));
        check("s0_not_done", 32'(done0), 32'd0);
      end
    end
    check("s0_done", 32'(done0), 32'd1);
    check("s0_captured", 32'(captured0), 32'(e.cap));
    check("s0_pass", 32'(pass0), 32'(e.pass));
    check("s0_mismatch", 32'(mismatch_cnt0), 32'(e.mm));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
